// File: rtl/axi_wr_burst_sink.sv
// AXI3-style write-only slave: accepts one burst at a time into a word memory,
// returns a per-burst B response and exposes a sideband read port plus counters.
module axi_wr_burst_sink #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    MEM_DEPTH  = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                         clk,
  input  logic                         areset,
  input  logic [3:0]                   awid_i,
  input  logic [ADDR_WIDTH-1:0]        awaddr_i,
  input  logic [3:0]                   awlen_i,
  input  logic [2:0]                   awsize_i,
  input  logic [1:0]                   awburst_i,
  input  logic                         awvalid_i,
  output logic                         awready_o,
  input  logic [3:0]                   wid_i,
  input  logic [DATA_WIDTH-1:0]        wdata_i,
  input  logic [3:0]                   wstrb_i,
  input  logic                         wlast_i,
  input  logic                         wvalid_i,
  output logic                         wready_o,
  output logic [3:0]                   bid_o,
  output logic [1:0]                   bresp_o,
  output logic                         bvalid_o,
  input  logic                         bready_i,
  input  logic [$clog2(MEM_DEPTH)-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0]        rd_data_o,
  output logic [15:0]                  burst_cnt_o,
  output logic [7:0]                   err_cnt_o
);

  localparam int IW = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t state, next_state;

  logic                  aw_hs, w_hs, b_hs, last_beat, beat_err;
  logic [ADDR_WIDTH-1:0] offset, idx_full;
  logic [ADDR_WIDTH:0]   end_idx;
  logic                  dec_err, slv_err_aw;
  logic [3:0]            id_q, len_q, beat_cnt;
  logic                  fixed_q, suppress_q;
  logic [IW-1:0]         start_q, wr_idx;
  logic [1:0]            resp_q;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  assign aw_hs = awready_o & awvalid_i;
  assign w_hs  = wready_o & wvalid_i;
  assign b_hs  = bvalid_o & bready_i;

  // Address classification is evaluated once, at the AW handshake.
  assign offset     = awaddr_i - BASE_ADDR;
  assign idx_full   = offset >> 2;
  assign end_idx    = {1'b0, idx_full} + (ADDR_WIDTH+1)'(awlen_i);
  assign dec_err    = (awaddr_i < BASE_ADDR) || (end_idx >= (ADDR_WIDTH+1)'(MEM_DEPTH));
  assign slv_err_aw = (awaddr_i[1:0] != 2'b00) || (awsize_i != 3'b010) || awburst_i[1];

  assign last_beat = (beat_cnt == len_q);
  assign beat_err  = (wid_i != id_q) || (wlast_i != last_beat);
  assign wr_idx    = fixed_q ? start_q : start_q + IW'(beat_cnt);

  assign bid_o   = id_q;
  assign bresp_o = resp_q;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (aw_hs)              next_state = DATA;
      DATA:    if (w_hs && last_beat)  next_state = RESP;
      RESP:    if (bready_i)           next_state = IDLE;
      default:                         next_state = IDLE;
    endcase
  end

  always_comb begin
    awready_o = 1'b0;
    wready_o  = 1'b0;
    bvalid_o  = 1'b0;
    case (state)
      IDLE:    awready_o = 1'b1;
      DATA:    wready_o  = 1'b1;
      RESP:    bvalid_o  = 1'b1;
      default: ;
    endcase
  end

  // Beat-level errors only downgrade OKAY; a decode error keeps its priority.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      id_q       <= '0;
      len_q      <= '0;
      beat_cnt   <= '0;
      fixed_q    <= 1'b0;
      suppress_q <= 1'b0;
      start_q    <= '0;
      resp_q     <= 2'b00;
    end else if (aw_hs) begin
      id_q       <= awid_i;
      len_q      <= awlen_i;
      beat_cnt   <= '0;
      fixed_q    <= (awburst_i == 2'b00);
      suppress_q <= dec_err | slv_err_aw;
      start_q    <= idx_full[IW-1:0];
      resp_q     <= dec_err ? 2'b11 : (slv_err_aw ? 2'b10 : 2'b00);
    end else if (w_hs) begin
      beat_cnt <= beat_cnt + 4'd1;
      if (beat_err && resp_q == 2'b00) resp_q <= 2'b10;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      burst_cnt_o <= '0;
      err_cnt_o   <= '0;
    end else if (b_hs) begin
      if (resp_q == 2'b00)       burst_cnt_o <= burst_cnt_o + 16'd1;
      else if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && !suppress_q) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_i[b]) mem[wr_idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Read-before-write: a same-cycle write is seen on the following read.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) rd_data_o <= '0;
    else        rd_data_o <= mem[rd_addr_i];
  end

endmodule

// File: tb/tb_axi_wr_burst_sink.sv
// Scoreboard bench for axi_wr_burst_sink: a reference memory and expected
// B responses are queued as bursts are driven and compared as the DUT answers.
module tb_axi_wr_burst_sink;

  localparam int          DEPTH = 256;
  localparam logic [63:0] BASE  = 64'h0;

  logic        clk = 1'b0;
  logic        areset;
  logic [3:0]  awid_i;
  logic [63:0] awaddr_i;
  logic [3:0]  awlen_i;
  logic [2:0]  awsize_i;
  logic [1:0]  awburst_i;
  logic        awvalid_i;
  logic        awready_o;
  logic [3:0]  wid_i;
  logic [31:0] wdata_i;
  logic [3:0]  wstrb_i;
  logic        wlast_i;
  logic        wvalid_i;
  logic        wready_o;
  logic [3:0]  bid_o;
  logic [1:0]  bresp_o;
  logic        bvalid_o;
  logic        bready_i;
  logic [7:0]  rd_addr_i;
  logic [31:0] rd_data_o;
  logic [15:0] burst_cnt_o;
  logic [7:0]  err_cnt_o;

  axi_wr_burst_sink #(
    .DATA_WIDTH(32), .ADDR_WIDTH(64), .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .areset(areset),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awsize_i(awsize_i),
    .awburst_i(awburst_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wid_i(wid_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i),
    .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
    .burst_cnt_o(burst_cnt_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } b_exp_t;

  b_exp_t      b_queue[$];
  logic [31:0] rd_queue[$];
  logic [31:0] model_mem[DEPTH];
  int          model_burst = 0;
  int          model_err = 0;
  int          pass_count = 0;
  int          total_count = 0;

  logic [31:0] beat_data[16];
  logic [3:0]  beat_strb[16];
  logic        beat_last[16];
  logic [3:0]  beat_wid[16];

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  task automatic set_beats(input logic [3:0] len, input logic [31:0] base_data, input logic [3:0] id);
    for (int i = 0; i < 16; i++) begin
      beat_data[i] = base_data + 32'(i);
      beat_strb[i] = 4'hF;
      beat_last[i] = (i == int'(len));
      beat_wid[i]  = id;
    end
  endtask

  task automatic drive_aw(input logic [3:0] id, input logic [63:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    int cyc = 0;
    awid_i = id; awaddr_i = addr; awlen_i = len; awsize_i = size; awburst_i = burst;
    awvalid_i = 1'b1;
    while (!awready_o && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    if (!awready_o) checkOutput("aw_timeout", 64'(awready_o), 64'd1);
    @(posedge clk); #1;
    awvalid_i = 1'b0;
  endtask

  task automatic drive_w(input int i);
    int cyc = 0;
    wid_i = beat_wid[i]; wdata_i = beat_data[i]; wstrb_i = beat_strb[i]; wlast_i = beat_last[i];
    wvalid_i = 1'b1;
    while (!wready_o && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    if (!wready_o) checkOutput("w_timeout", 64'(wready_o), 64'd1);
    @(posedge clk); #1;
    wvalid_i = 1'b0; wlast_i = 1'b0;
  endtask

  // Drives one full burst, updates the reference memory and queues the expected B.
  task automatic applyStimulus(input logic [3:0] id, input logic [63:0] addr, input logic [3:0] len,
                               input logic [2:0] size, input logic [1:0] burst);
    logic [63:0] idx;
    logic        dec, slv_aw, slv_beat;
    int          widx;
    b_exp_t      e;
    idx      = (addr - BASE) >> 2;
    dec      = (addr < BASE) || (idx + 64'(len) >= 64'(DEPTH));
    slv_aw   = (addr[1:0] != 2'b00) || (size != 3'b010) || (burst == 2'b10) || (burst == 2'b11);
    slv_beat = 1'b0;
    drive_aw(id, addr, len, size, burst);
    checkOutput("wready_after_aw", 64'(wready_o), 64'd1);
    for (int i = 0; i <= int'(len); i++) begin
      if (beat_wid[i] != id || beat_last[i] != (i == int'(len))) slv_beat = 1'b1;
      if (!dec && !slv_aw) begin
        widx = (burst == 2'b00) ? int'(idx) : int'(idx) + i;
        for (int b = 0; b < 4; b++)
          if (beat_strb[i][b]) model_mem[widx][8*b +: 8] = beat_data[i][8*b +: 8];
      end
      drive_w(i);
    end
    e.id   = id;
    e.resp = dec ? 2'b11 : ((slv_aw || slv_beat) ? 2'b10 : 2'b00);
    b_queue.push_back(e);
    checkOutput("bvalid_after_last", 64'(bvalid_o), 64'd1);
  endtask

  task automatic recv_b(input int hold);
    int     cyc = 0;
    b_exp_t e;
    while (!bvalid_o && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    checkOutput("bvalid_seen", 64'(bvalid_o), 64'd1);
    if (b_queue.size() == 0) begin
      checkOutput("b_unexpected", 64'(b_queue.size()), 64'd1);
      return;
    end
    e = b_queue.pop_front();
    for (int h = 0; h < hold; h++) begin
      awid_i = 4'hE; awaddr_i = 64'h100; awlen_i = 4'd0; awsize_i = 3'b010; awburst_i = 2'b01;
      awvalid_i = 1'b1;
      @(posedge clk); #1;
      checkOutput("bp_bvalid", 64'(bvalid_o), 64'd1);
      checkOutput("bp_bresp", 64'(bresp_o), 64'(e.resp));
      checkOutput("bp_awready", 64'(awready_o), 64'd0);
    end
    checkOutput("bid", 64'(bid_o), 64'(e.id));
    checkOutput("bresp", 64'(bresp_o), 64'(e.resp));
    bready_i = 1'b1;
    @(posedge clk); #1;
    bready_i = 1'b0; awvalid_i = 1'b0;
    if (e.resp == 2'b00) model_burst++;
    else if (model_err < 255) model_err++;
    checkOutput("awready_after_b", 64'(awready_o), 64'd1);
    checkOutput("bvalid_after_b", 64'(bvalid_o), 64'd0);
    checkOutput("burst_cnt", 64'(burst_cnt_o), 64'(model_burst));
    checkOutput("err_cnt", 64'(err_cnt_o), 64'(model_err));
    if (hold > 0) begin
      @(posedge clk); #1;
      checkOutput("late_aw_ignored", 64'(wready_o), 64'd0);
    end
  endtask

  task automatic check_mem(input int idx);
    rd_queue.push_back(model_mem[idx]);
    rd_addr_i = 8'(idx);
    @(posedge clk); #1;
    checkOutput($sformatf("mem[%0d]", idx), 64'(rd_data_o), 64'(rd_queue.pop_front()));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    areset = 1'b1;
    awid_i = '0; awaddr_i = '0; awlen_i = '0; awsize_i = 3'b010; awburst_i = 2'b01; awvalid_i = 1'b0;
    wid_i = '0; wdata_i = '0; wstrb_i = '0; wlast_i = 1'b0; wvalid_i = 1'b0;
    bready_i = 1'b0; rd_addr_i = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_wready", 64'(wready_o), 64'd0);
    checkOutput("rst_bvalid", 64'(bvalid_o), 64'd0);
    checkOutput("rst_bid", 64'(bid_o), 64'd0);
    checkOutput("rst_bresp", 64'(bresp_o), 64'd0);
    checkOutput("rst_rd_data", 64'(rd_data_o), 64'd0);
    checkOutput("rst_burst_cnt", 64'(burst_cnt_o), 64'd0);
    checkOutput("rst_err_cnt", 64'(err_cnt_o), 64'd0);
    areset = 1'b0;
    #1;
    checkOutput("rst_awready", 64'(awready_o), 64'd1);

    // Single INCR burst into words 4..7.
    set_beats(4'd3, 32'hA0, 4'd5);
    applyStimulus(4'd5, BASE + 64'h10, 4'd3, 3'b010, 2'b01);
    recv_b(0);
    for (int i = 4; i < 8; i++) check_mem(i);

    // Strobed FIXED burst over a preset word 0.
    set_beats(4'd0, 32'hFFFF_FFFF, 4'd1);
    applyStimulus(4'd1, BASE, 4'd0, 3'b010, 2'b01);
    recv_b(0);
    set_beats(4'd1, 32'h0, 4'd2);
    beat_data[0] = 32'h1122_3344; beat_strb[0] = 4'b0001;
    beat_data[1] = 32'h5566_7788; beat_strb[1] = 4'b1000;
    applyStimulus(4'd2, BASE, 4'd1, 3'b010, 2'b00);
    recv_b(1);
    rd_addr_i = 8'd0;
    @(posedge clk); #1;
    checkOutput("fixed_strobe", 64'(rd_data_o), 64'h55FF_FF44);

    // Last in-range burst, then a decode error that overlaps it.
    set_beats(4'd3, 32'hC0DE_0000, 4'd3);
    applyStimulus(4'd3, BASE + 64'(4 * (DEPTH - 4)), 4'd3, 3'b010, 2'b01);
    recv_b(0);
    set_beats(4'd3, 32'hDEAD_0000, 4'd4);
    applyStimulus(4'd4, BASE + 64'(4 * (DEPTH - 2)), 4'd3, 3'b010, 2'b01);
    recv_b(0);
    check_mem(DEPTH - 2);
    check_mem(DEPTH - 1);

    // Address and size errors suppress writes; a wid error does not.
    set_beats(4'd1, 32'h0808_0000, 4'd6);
    applyStimulus(4'd6, BASE + 64'h20, 4'd1, 3'b010, 2'b01);
    recv_b(0);
    set_beats(4'd1, 32'hBAD0_0000, 4'd7);
    applyStimulus(4'd7, BASE + 64'h22, 4'd1, 3'b010, 2'b01);
    recv_b(0);
    set_beats(4'd0, 32'hBAD1_0000, 4'd8);
    applyStimulus(4'd8, BASE + 64'h20, 4'd0, 3'b011, 2'b01);
    recv_b(0);
    check_mem(8);
    check_mem(9);
    set_beats(4'd1, 32'h3030_0000, 4'd9);
    beat_wid[1] = 4'd3;
    applyStimulus(4'd9, BASE + 64'h30, 4'd1, 3'b010, 2'b01);
    recv_b(0);
    check_mem(12);
    check_mem(13);

    // Early wlast still runs the full burst; B held off for five cycles.
    set_beats(4'd2, 32'h6060_0000, 4'hA);
    beat_last[1] = 1'b1; beat_last[2] = 1'b0;
    applyStimulus(4'hA, BASE + 64'h60, 4'd2, 3'b010, 2'b01);
    recv_b(5);
    for (int i = 24; i < 27; i++) check_mem(i);

    // Reset after two beats of a four-beat burst.
    set_beats(4'd3, 32'h4040_0000, 4'hB);
    drive_aw(4'hB, BASE + 64'h40, 4'd3, 3'b010, 2'b01);
    drive_w(0);
    drive_w(1);
    model_mem[16] = beat_data[0];
    model_mem[17] = beat_data[1];
    areset = 1'b1;
    #1;
    checkOutput("midrst_awready", 64'(awready_o), 64'd1);
    checkOutput("midrst_wready", 64'(wready_o), 64'd0);
    checkOutput("midrst_bvalid", 64'(bvalid_o), 64'd0);
    checkOutput("midrst_burst_cnt", 64'(burst_cnt_o), 64'd0);
    checkOutput("midrst_err_cnt", 64'(err_cnt_o), 64'd0);
    checkOutput("midrst_rd_data", 64'(rd_data_o), 64'd0);
    @(posedge clk); #1;
    areset = 1'b0;
    model_burst = 0;
    model_err = 0;
    check_mem(16);
    check_mem(17);
    set_beats(4'd1, 32'h8080_0000, 4'hC);
    applyStimulus(4'hC, BASE + 64'h80, 4'd1, 3'b010, 2'b01);
    recv_b(0);
    check_mem(32);
    check_mem(33);

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
